// File: rtl/microwave_controller.sv
// microwave_controller: front-panel sequencer for the microwave cook timer.
// Shift-loads keypad digits into the external mm:ss down-counter, issues its
// 1 Hz decrement strobe, runs the magnetron and the end-of-cook beeper.
// Ports:
//   clock, clrn          rising-edge clock, asynchronous active-low reset
//   key_valid, key_digit keypress strobe and BCD digit (10-15 ignored)
//   start, stop          1-cycle panel strobes
//   door_closed          door switch level (1 = shut)
//   timer_zero           timer reads 0:00
//   timer_data/load      shift-load digit and strobe (data->ones->tens->mins)
//   timer_enable         1-cycle decrement strobe
//   magnetron_on, beep   heater and beeper drives
//   state_dbg            current state encoding
module microwave_controller #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter int unsigned ZERO_LATENCY  = 2,
  parameter int unsigned BEEP_CYCLES   = 25_000_000
) (
  input  logic       clock,
  input  logic       clrn,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  input  logic       timer_zero,
  output logic [3:0] timer_data,
  output logic       timer_load,
  output logic       timer_enable,
  output logic       magnetron_on,
  output logic       beep,
  output logic [2:0] state_dbg
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned BW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [BW-1:0] BEEP_LAST  = BW'(BEEP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ENTRY  = 3'd1,
    COOK   = 3'd2,
    PAUSED = 3'd3,
    DONE   = 3'd4,
    CLEAR  = 3'd5
  } state_t;

  state_t                  state, state_nx;
  logic [PW-1:0]           presc, presc_nx;
  logic [BW-1:0]           beep_cnt, beep_cnt_nx;
  logic [1:0]              digits, digits_nx;
  logic [1:0]              clr_cnt, clr_cnt_nx;
  logic [ZERO_LATENCY-1:0] zchk;
  logic                    load_nx, enable_nx;
  logic [3:0]              data_nx;
  logic                    zero_seen, key_ok, start_ok;

  // zchk delays each decrement strobe so timer_zero is only trusted once the
  // timer has had ZERO_LATENCY cycles to settle after that decrement.
  assign zero_seen = zchk[ZERO_LATENCY-1] & timer_zero;
  assign key_ok    = key_valid && (key_digit <= 4'd9) && (digits != 2'd3);
  assign start_ok  = start && door_closed && !timer_zero;
  assign state_dbg = state;

  always_comb begin
    state_nx    = state;
    presc_nx    = presc;
    beep_cnt_nx = '0;
    digits_nx   = digits;
    clr_cnt_nx  = '0;
    load_nx     = 1'b0;
    enable_nx   = 1'b0;
    data_nx     = '0;
    case (state)
      IDLE, ENTRY: begin
        // A rejected start does not swallow a simultaneous keypress.
        if (stop) begin
          digits_nx = '0;
          if (state == ENTRY) begin
            state_nx = CLEAR;
            load_nx  = 1'b1;
          end
        end else if (state == ENTRY && start_ok) begin
          state_nx = COOK;
          presc_nx = '0;
        end else if (key_ok) begin
          load_nx   = 1'b1;
          data_nx   = key_digit;
          digits_nx = digits + 2'd1;
          state_nx  = ENTRY;
        end
      end
      COOK: begin
        // The prescaler advances on every COOK cycle, including the one that
        // leaves COOK, so a wrap coinciding with a pause still ticks.
        enable_nx = (presc == PRESC_LAST);
        presc_nx  = (presc == PRESC_LAST) ? '0 : presc + PW'(1);
        // A finished timer outranks a pause request: pausing at 0:00 would
        // leave an unresumable state.
        if (zero_seen)                state_nx = DONE;
        else if (stop || !door_closed) state_nx = PAUSED;
      end
      PAUSED: begin
        if (zero_seen) begin
          state_nx = DONE;
        end else if (stop) begin
          state_nx = CLEAR;
          load_nx  = 1'b1;
        end else if (start_ok) begin
          state_nx = COOK;
        end
      end
      DONE: begin
        beep_cnt_nx = beep_cnt + BW'(1);
        if (stop || beep_cnt == BEEP_LAST) begin
          state_nx  = IDLE;
          digits_nx = '0;
        end
      end
      CLEAR: begin
        if (clr_cnt == 2'd2) begin
          state_nx  = IDLE;
          digits_nx = '0;
        end else begin
          clr_cnt_nx = clr_cnt + 2'd1;
          load_nx    = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state        <= IDLE;
      presc        <= '0;
      beep_cnt     <= '0;
      digits       <= '0;
      clr_cnt      <= '0;
      zchk         <= '0;
      timer_data   <= '0;
      timer_load   <= 1'b0;
      timer_enable <= 1'b0;
      magnetron_on <= 1'b0;
      beep         <= 1'b0;
    end else begin
      state        <= state_nx;
      presc        <= presc_nx;
      beep_cnt     <= beep_cnt_nx;
      digits       <= digits_nx;
      clr_cnt      <= clr_cnt_nx;
      zchk         <= (zchk << 1) | ZERO_LATENCY'(timer_enable);
      timer_data   <= data_nx;
      timer_load   <= load_nx;
      timer_enable <= enable_nx;
      magnetron_on <= (state_nx == COOK);
      beep         <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_microwave_controller.sv
// tb_microwave_controller: table vectors, directed cook/pause/clear/reset
// sequences and a randomized run against a behavioural model. Includes a
// BCD mm:ss timer model driving timer_zero.
module tb_microwave_controller;

  localparam int TPS  = 4;
  localparam int ZL   = 2;
  localparam int BEEP = 8;

  localparam int M_IDLE = 0, M_ENTRY = 1, M_COOK = 2, M_PAUSED = 3, M_DONE = 4, M_CLEAR = 5;

  logic       clock = 1'b0;
  logic       clrn = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       door_closed = 1'b1;
  logic       timer_zero;
  logic [3:0] timer_data;
  logic       timer_load, timer_enable, magnetron_on, beep;
  logic [2:0] state_dbg;

  int passed = 0;
  int total  = 0;

  microwave_controller #(.TICKS_PER_SEC(TPS), .ZERO_LATENCY(ZL), .BEEP_CYCLES(BEEP)) dut (
    .clock(clock), .clrn(clrn), .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .stop(stop), .door_closed(door_closed), .timer_zero(timer_zero),
    .timer_data(timer_data), .timer_load(timer_load), .timer_enable(timer_enable),
    .magnetron_on(magnetron_on), .beep(beep), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  // External mm:ss timer
  logic [3:0] t_min = '0, t_ten = '0, t_one = '0;
  assign timer_zero = (t_min == 4'd0) && (t_ten == 4'd0) && (t_one == 4'd0);
  always @(posedge clock) begin
    if (timer_load) begin
      t_min <= t_ten;
      t_ten <= t_one;
      t_one <= timer_data;
    end else if (timer_enable && !timer_zero) begin
      if (t_one != 4'd0) t_one <= t_one - 4'd1;
      else begin
        t_one <= 4'd9;
        if (t_ten != 4'd0) t_ten <= t_ten - 4'd1;
        else begin
          t_ten <= 4'd5;
          t_min <= t_min - 4'd1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [10:0] obs();
    return {state_dbg, timer_load, timer_data, timer_enable, magnetron_on, beep};
  endfunction

  task automatic do_reset();
    clrn = 1'b0; key_valid = 1'b0; key_digit = '0; start = 1'b0; stop = 1'b0; door_closed = 1'b1;
    tick(); tick();
    clrn = 1'b1;
    tick();
  endtask

  task automatic press_key(input logic [3:0] d);
    key_valid = 1'b1; key_digit = d;
    tick();
    key_valid = 1'b0;
    check($sformatf("key_load_%0d", d), {timer_load, timer_data}, {1'b1, d});
  endtask

  task automatic press_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  // Behavioural reference: mode plus counters for digits entered, prescaler
  // phase, beep and clear cycles left, and a queue of cycles at which a zero
  // check is due.
  int m_mode, m_digits, m_phase, m_beep_left, m_clear_left;
  int m_due[$];
  logic [10:0] m_obs;

  task automatic model_reset();
    m_mode = M_IDLE; m_digits = 0; m_phase = 0; m_beep_left = 0; m_clear_left = 0;
    m_due.delete();
  endtask

  task automatic model_step(input int n);
    bit due, tz, ld, en;
    logic [3:0] dt;
    tz = timer_zero; due = 0; ld = 0; en = 0; dt = '0;
    if (m_due.size() != 0 && m_due[0] == n) begin
      due = 1; m_due.delete(0);
    end
    if (m_mode == M_IDLE || m_mode == M_ENTRY) begin
      if (stop) begin
        if (m_mode == M_ENTRY) begin m_mode = M_CLEAR; ld = 1; m_clear_left = 2; end
        m_digits = 0;
      end else if (m_mode == M_ENTRY && start && door_closed && !tz) begin
        m_mode = M_COOK; m_phase = 0;
      end else if (key_valid && key_digit < 10 && m_digits < 3) begin
        ld = 1; dt = key_digit; m_digits++; m_mode = M_ENTRY;
      end
    end else if (m_mode == M_COOK) begin
      if (m_phase == TPS - 1) begin en = 1; m_due.push_back(n + 1 + ZL); end
      m_phase = (m_phase + 1) % TPS;
      if (due && tz) begin m_mode = M_DONE; m_beep_left = BEEP; end
      else if (stop || !door_closed) m_mode = M_PAUSED;
    end else if (m_mode == M_PAUSED) begin
      if (due && tz) begin m_mode = M_DONE; m_beep_left = BEEP; end
      else if (stop) begin m_mode = M_CLEAR; ld = 1; m_clear_left = 2; end
      else if (start && door_closed && !tz) m_mode = M_COOK;
    end else if (m_mode == M_DONE) begin
      m_beep_left--;
      if (stop || m_beep_left == 0) begin m_mode = M_IDLE; m_digits = 0; end
    end else begin
      if (m_clear_left > 0) begin ld = 1; m_clear_left--; end
      else begin m_mode = M_IDLE; m_digits = 0; end
    end
    m_obs = {3'(m_mode), ld, dt, en, (m_mode == M_COOK), (m_mode == M_DONE)};
  endtask

  typedef struct packed {
    logic       kv;
    logic [3:0] kd;
    logic       st, sp, door;
    logic [2:0] st_e;
    logic       ld;
    logic [3:0] dt;
    logic       tz;
  } vec_t;

  initial begin
    #2_000_000;
    total++;
    $display("FAIL watchdog: got timeout required completion");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    vec_t vt[21];
    logic [11:0] m12;
    logic [10:0] m11;
    logic [7:0]  m8;
    logic [5:0]  m6;
    logic        mag_all;
    int          nb;

    // kv kd st sp door | state ld data tz
    vt[0]  = '{1'b1, 4'd5,  1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 4'd5, 1'b1};
    vt[1]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 4'd0, 1'b0};
    vt[2]  = '{1'b1, 4'd9,  1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 4'd9, 1'b0};
    vt[3]  = '{1'b1, 4'd9,  1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 4'd9, 1'b0};
    vt[4]  = '{1'b1, 4'd7,  1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 4'd0, 1'b0};
    vt[5]  = '{1'b1, 4'd12, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 4'd0, 1'b0};
    vt[6]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 4'd0, 1'b0};
    vt[7]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 3'd5, 1'b1, 4'd0, 1'b0};
    vt[8]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 3'd5, 1'b1, 4'd0, 1'b0};
    vt[9]  = '{1'b1, 4'd3,  1'b0, 1'b0, 1'b1, 3'd5, 1'b1, 4'd0, 1'b0};
    vt[10] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 4'd0, 1'b1};
    vt[11] = '{1'b1, 4'd10, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 4'd0, 1'b1};
    vt[12] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 4'd0, 1'b1};
    vt[13] = '{1'b1, 4'd1,  1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 4'd1, 1'b1};
    vt[14] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 4'd0, 1'b0};
    vt[15] = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 3'd5, 1'b1, 4'd0, 1'b0};
    vt[16] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 3'd5, 1'b1, 4'd0, 1'b0};
    vt[17] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 3'd5, 1'b1, 4'd0, 1'b0};
    vt[18] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 4'd0, 1'b1};
    vt[19] = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 4'd0, 1'b1};
    vt[20] = '{1'b1, 4'd4,  1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 4'd4, 1'b1};

    // Reset state
    tick(); tick();
    check("reset_state", {21'd0, obs()}, 32'd0);
    clrn = 1'b1;
    tick();

    // Table vectors: entry, ignored keys, rejected starts, clears
    for (int i = 0; i < 21; i++) begin
      key_valid = vt[i].kv; key_digit = vt[i].kd; start = vt[i].st;
      stop = vt[i].sp; door_closed = vt[i].door;
      tick();
      check($sformatf("vec%0d", i),
            {state_dbg, timer_load, timer_data, timer_enable, magnetron_on, beep, timer_zero},
            {vt[i].st_e, vt[i].ld, vt[i].dt, 3'b000, vt[i].tz});
    end

    // 1:30 cook, tick every 4 cycles
    do_reset();
    press_key(4'd1); press_key(4'd3); press_key(4'd0);
    tick();
    check("timer_130", {t_min, t_ten, t_one}, {4'd1, 4'd3, 4'd0});
    press_start();
    check("cook_start", {state_dbg, magnetron_on}, {3'd2, 1'b1});
    m12 = '0; mag_all = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick(); m12[k] = timer_enable; mag_all &= magnetron_on;
    end
    check("enable_period", m12, 12'b1000_1000_1000);
    check("mag_held", mag_all, 1'b1);

    // Door opens mid-cook, then resume with prescaler phase kept
    tick();
    check("timer_127", {t_min, t_ten, t_one}, {4'd1, 4'd2, 4'd7});
    door_closed = 1'b0;
    tick();
    check("door_pause", {state_dbg, magnetron_on}, {3'd3, 1'b0});
    press_start();
    check("start_door_open", state_dbg, 3'd3);
    m8 = '0;
    for (int k = 0; k < 8; k++) begin
      tick(); m8[k] = timer_enable;
    end
    check("no_tick_paused", m8, 8'd0);
    check("timer_frozen", {t_min, t_ten, t_one}, {4'd1, 4'd2, 4'd7});
    door_closed = 1'b1;
    press_start();
    check("resume", {state_dbg, magnetron_on}, {3'd2, 1'b1});
    m6 = '0;
    for (int k = 0; k < 6; k++) begin
      tick(); m6[k] = timer_enable;
    end
    check("resume_phase", m6, 6'b100010);

    // 0:02 cook to DONE, 8-cycle beep, IDLE
    do_reset();
    press_key(4'd0); press_key(4'd0); press_key(4'd2);
    tick();
    check("timer_002", {timer_zero, t_min, t_ten, t_one}, {1'b0, 4'd0, 4'd0, 4'd2});
    press_start();
    m11 = '0;
    for (int k = 0; k < 11; k++) begin
      tick(); m11[k] = timer_enable;
      if (k == 9) check("still_cook", {state_dbg, magnetron_on}, {3'd2, 1'b1});
    end
    check("done_ticks", m11, 11'b000_1000_1000);
    check("done_entry", {state_dbg, beep, magnetron_on}, {3'd4, 1'b1, 1'b0});
    nb = 1;
    while (beep && nb < 20) begin
      tick();
      if (beep) nb++;
    end
    check("beep_len", nb, BEEP);
    check("done_idle", {state_dbg, beep, timer_zero}, {3'd0, 1'b0, 1'b1});

    // Door opens on the wrap cycle: tick still issued; keys ignored; stop clears
    do_reset();
    press_key(4'd4); press_key(4'd2); press_key(4'd1);
    tick();
    press_start();
    tick(); tick(); tick();
    door_closed = 1'b0;
    tick();
    door_closed = 1'b1;
    check("tick_on_pause", {state_dbg, magnetron_on, timer_enable}, {3'd3, 1'b0, 1'b1});
    key_valid = 1'b1; key_digit = 4'd7;
    tick();
    key_valid = 1'b0;
    check("key_in_pause", {state_dbg, timer_load}, {3'd3, 1'b0});
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("clear0", {state_dbg, timer_load, timer_data}, {3'd5, 1'b1, 4'd0});
    tick();
    check("clear1", {state_dbg, timer_load, timer_data}, {3'd5, 1'b1, 4'd0});
    tick();
    check("clear2", {state_dbg, timer_load, timer_data}, {3'd5, 1'b1, 4'd0});
    tick();
    check("clear_idle", {state_dbg, timer_load, timer_zero}, {3'd0, 1'b0, 1'b1});

    // stop in DONE ends beep at once
    do_reset();
    press_key(4'd0); press_key(4'd0); press_key(4'd1);
    tick();
    press_start();
    repeat (7) tick();
    check("done_short", {state_dbg, beep}, {3'd4, 1'b1});
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("done_stop", {state_dbg, beep}, {3'd0, 1'b0});

    // Asynchronous reset mid-cook
    do_reset();
    press_key(4'd0); press_key(4'd5); press_key(4'd0);
    tick();
    press_start();
    repeat (3) tick();
    check("precook", magnetron_on, 1'b1);
    #2 clrn = 1'b0;
    #1 check("async_reset", {21'd0, obs()}, 32'd0);
    tick();
    clrn = 1'b1;
    tick();
    check("post_reset", {21'd0, obs()}, 32'd0);

    // Randomized run against the behavioural model
    do_reset();
    model_reset();
    for (int n = 0; n < 4000; n++) begin
      key_valid   = ($urandom_range(0, 99) < 25);
      key_digit   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 1)) : 4'($urandom_range(0, 15));
      start       = ($urandom_range(0, 99) < 12);
      stop        = ($urandom_range(0, 99) < 3);
      door_closed = ($urandom_range(0, 99) < 94);
      model_step(n);
      tick();
      check($sformatf("rand@%0d", n), {21'd0, obs()}, {21'd0, m_obs});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
